gpr: RTL and testbench

// - MIPS general-purpose register file: 32 x 32-bit, two async read ports, one sync write port.
// - Sits in the datapath decode stage, between instruction decode (A1/A2/A3) and ALU / writeback (Wd).
// - Register $0 is hard-wired to zero.

---
 rtl/gpr_pkg.sv | 40 ++++
 rtl/gpr_rd_port.sv | 20 ++
 rtl/gpr.sv | 52 +++++
 tb/tb_gpr.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/gpr_pkg.sv
// gpr_pkg: shared widths, types and MIPS register names for the register file.
package gpr_pkg;
    localparam int GPR_DATA_W = 32;
    localparam int GPR_ADDR_W = 5;
    localparam int GPR_NUM    = 32;
    typedef logic [GPR_ADDR_W-1:0] gpr_addr_t;
    typedef logic [GPR_DATA_W-1:0] gpr_data_t;
    localparam gpr_addr_t REG_ZERO = 5'd0;
    localparam gpr_addr_t REG_AT   = 5'd1;
    localparam gpr_addr_t REG_V0   = 5'd2;
    localparam gpr_addr_t REG_V1   = 5'd3;
    localparam gpr_addr_t REG_A0   = 5'd4;
    localparam gpr_addr_t REG_A1   = 5'd5;
    localparam gpr_addr_t REG_A2   = 5'd6;
    localparam gpr_addr_t REG_A3   = 5'd7;
    localparam gpr_addr_t REG_T0   = 5'd8;
    localparam gpr_addr_t REG_T1   = 5'd9;
    localparam gpr_addr_t REG_T2   = 5'd10;
    localparam gpr_addr_t REG_T3   = 5'd11;
    localparam gpr_addr_t REG_T4   = 5'd12;
    localparam gpr_addr_t REG_T5   = 5'd13;
    localparam gpr_addr_t REG_T6   = 5'd14;
    localparam gpr_addr_t REG_T7   = 5'd15;
    localparam gpr_addr_t REG_S0   = 5'd16;
    localparam gpr_addr_t REG_S1   = 5'd17;
    localparam gpr_addr_t REG_S2   = 5'd18;
    localparam gpr_addr_t REG_S3   = 5'd19;
    localparam gpr_addr_t REG_S4   = 5'd20;
    localparam gpr_addr_t REG_S5   = 5'd21;
    localparam gpr_addr_t REG_S6   = 5'd22;
    localparam gpr_addr_t REG_S7   = 5'd23;
    localparam gpr_addr_t REG_T8   = 5'd24;
    localparam gpr_addr_t REG_T9   = 5'd25;
    localparam gpr_addr_t REG_K0   = 5'd26;
    localparam gpr_addr_t REG_K1   = 5'd27;
    localparam gpr_addr_t REG_GP   = 5'd28;
    localparam gpr_addr_t REG_SP   = 5'd29;
    localparam gpr_addr_t REG_FP   = 5'd30;
    localparam gpr_addr_t REG_RA   = 5'd31;
endpackage

// File: rtl/gpr_rd_port.sv
// gpr_rd_port: one combinational read port; $0 reads zero, optional write-through.
module gpr_rd_port
    import gpr_pkg::*;
#(
    parameter int DATA_W = GPR_DATA_W,
    parameter int ADDR_W = GPR_ADDR_W,
    parameter int BYPASS = 0
) (
    input  logic [2**ADDR_W-1:0][DATA_W-1:0] regs_i,
    input  logic [ADDR_W-1:0]                addr_i,
    input  logic                             we_i,
    input  logic [ADDR_W-1:0]                waddr_i,
    input  logic [DATA_W-1:0]                wdata_i,
    output logic [DATA_W-1:0]                rdata_o
);
    always_comb begin
        rdata_o = (addr_i == '0) ? '0 :
                  ((BYPASS != 0) && we_i && (waddr_i == addr_i)) ? wdata_i : regs_i[addr_i];
    end
endmodule

// File: rtl/gpr.sv
// gpr: MIPS 32x32 register file, two async read ports, one sync write port, $0 hard-wired to zero.
module gpr
    import gpr_pkg::*;
#(
    parameter int DATA_W = GPR_DATA_W,
    parameter int ADDR_W = GPR_ADDR_W,
    parameter int BYPASS = 0
) (
    input  logic              Regwrite,
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] Wd,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    input  logic [ADDR_W-1:0] A3,
    output logic [DATA_W-1:0] Rd1,
    output logic [DATA_W-1:0] Rd2
);
    logic [2**ADDR_W-1:0][DATA_W-1:0] regs_q, regs_d;
    logic                             we;

    // Bypass must stay silent while Reset holds the file cleared.
    assign we = Reset && (Regwrite == 1'b1);

    always_comb begin
        regs_d = regs_q;
        if (we && (A3 != '0)) regs_d[A3] = Wd;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) regs_q <= '0;
        else        regs_q <= regs_d;
    end

    gpr_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rd1 (
        .regs_i (regs_q),
        .addr_i (A1),
        .we_i   (we),
        .waddr_i(A3),
        .wdata_i(Wd),
        .rdata_o(Rd1)
    );

    gpr_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rd2 (
        .regs_i (regs_q),
        .addr_i (A2),
        .we_i   (we),
        .waddr_i(A3),
        .wdata_i(Wd),
        .rdata_o(Rd2)
    );
endmodule

// File: tb/tb_gpr.sv
// tb_gpr: scoreboard bench driving a plain and a write-through register file in lockstep.
module tb_gpr;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Regwrite = 1'b0;
    logic [31:0] Wd = '0;
    logic [4:0]  A1 = '0, A2 = '0, A3 = '0;
    logic [31:0] rd1_n, rd2_n, rd1_b, rd2_b;

    typedef struct {
        string       name;
        logic [31:0] n1, n2, b1, b2;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model[32];
    int          checks = 0;
    int          errors = 0;
    event        sample_ev;

    always #10 Clk = ~Clk;

    gpr #(.BYPASS(0)) u_plain (
        .Regwrite(Regwrite), .Clk(Clk), .Reset(Reset), .Wd(Wd),
        .A1(A1), .A2(A2), .A3(A3), .Rd1(rd1_n), .Rd2(rd2_n)
    );

    gpr #(.BYPASS(1)) u_byp (
        .Regwrite(Regwrite), .Clk(Clk), .Reset(Reset), .Wd(Wd),
        .A1(A1), .A2(A2), .A3(A3), .Rd1(rd1_b), .Rd2(rd2_b)
    );

    function automatic void cmp(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endfunction

    // What a register read should return, straight from the architectural rules.
    function automatic logic [31:0] exp_rd(logic [4:0] a, bit byp);
        if (Reset !== 1'b1 || a == 5'd0) return 32'h0;
        if (byp && Regwrite === 1'b1 && A3 == a) return Wd;
        return model[a];
    endfunction

    task automatic clear_model();
        foreach (model[i]) model[i] = 32'h0;
    endtask

    task automatic set_reset(logic v);
        Reset = v;
        if (!v) clear_model();
    endtask

    task automatic drive(logic rw, logic [4:0] a1, logic [4:0] a2, logic [4:0] a3, logic [31:0] wd);
        Regwrite = rw; A1 = a1; A2 = a2; A3 = a3; Wd = wd;
    endtask

    task automatic check(string name);
        exp_t e;
        #1;
        e.name = name;
        e.n1 = exp_rd(A1, 1'b0); e.n2 = exp_rd(A2, 1'b0);
        e.b1 = exp_rd(A1, 1'b1); e.b2 = exp_rd(A2, 1'b1);
        sb.push_back(e);
        ->sample_ev;
        #1;
    endtask

    task automatic tick();
        @(posedge Clk);
        if (Reset === 1'b1 && Regwrite === 1'b1 && A3 != 5'd0) model[A3] = Wd;
        #2;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(sample_ev);
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL scoreboard: got empty queue expected an entry");
            end else begin
                e = sb.pop_front();
                cmp({e.name, "/plain_rd1"}, rd1_n, e.n1);
                cmp({e.name, "/plain_rd2"}, rd2_n, e.n2);
                cmp({e.name, "/byp_rd1"}, rd1_b, e.b1);
                cmp({e.name, "/byp_rd2"}, rd2_b, e.b2);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        clear_model();
        #1;
        set_reset(1'b0);
        drive(1'bx, 5'd8, 5'd9, 5'd8, 32'hAAAA_AAAA);
        check("rst_low");
        tick(); check("rst_edge1");
        tick(); check("rst_edge2");
        drive(1'b1, 5'd8, 5'd9, 5'd8, 32'hAAAA_AAAA);
        set_reset(1'b1);
        check("wr8_pre");
        tick(); check("wr8_post");
        A2 = 5'd8; A1 = 5'd6;
        check("addr_switch");
        drive(1'b1, 5'd0, 5'd8, 5'd0, 32'hFFFF_FFFF);
        check("zero_pre");
        tick(); check("zero_post");
        drive(1'b1, 5'd31, 5'd8, 5'd31, 32'h1234_5678);
        tick(); check("wr31");
        Regwrite = 1'b0;
        #3;
        set_reset(1'b0);
        check("rst_pulse");
        tick(); check("rst_hold1");
        tick(); check("rst_hold2");
        set_reset(1'b1);
        drive(1'b1, 5'd5, 5'd5, 5'd5, 32'h1111_1111);
        tick(); check("wr5");
        drive(1'b0, 5'd5, 5'd31, 5'd5, 32'hDEAD_BEEF);
        check("nowr_pre");
        tick(); check("nowr_post");
        Regwrite = 1'b1;
        check("bypass_pre");
        tick(); check("bypass_post");
        for (int i = 0; i < 300; i++) begin
            logic [4:0] a1, a2, a3;
            a1 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            a3 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            drive(1'($urandom_range(0, 1)), a1, a2, a3, $urandom);
            if ($urandom_range(0, 24) == 0) begin
                set_reset(1'b0);
                check("rnd_rst");
                set_reset(1'b1);
            end
            check("rnd_pre");
            tick();
            check("rnd_post");
        end
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
